// File: rtl/mem_pkg.sv
// mem_pkg: shared types for the row-buffer memory controller
package mem_pkg;
  localparam int LINE_W = 512;
  localparam int TNUM_2_DEF = 18;
  localparam int INUM_2_DEF = 8;
  typedef logic [LINE_W-1:0] line_t;
  typedef enum logic [1:0] {IDLE, BUSY, RESP, GAP} state_t;
endpackage

// File: rtl/mem_line_array.sv
// mem_line_array: 2^AW line store, synchronous write, combinational read
module mem_line_array
  import mem_pkg::*;
#(
  parameter int AW = 10,
  parameter INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  line_t         wdata,
  input  logic [AW-1:0] raddr,
  output line_t         rdata
);
  line_t mem [2**AW];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/mem_ctrl_rowbuf.sv
// mem_ctrl_rowbuf: L2 line backing store with open-row hit/miss latency model
module mem_ctrl_rowbuf
  import mem_pkg::*;
#(
  parameter int TNUM_2 = TNUM_2_DEF,
  parameter int INUM_2 = INUM_2_DEF,
  parameter int AW = 10,
  parameter int COL_BITS = 4,
  parameter int T_HIT = 4,
  parameter int T_MISS = 12,
  parameter INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              read_L2_MEM,
  input  logic              write_L2_MEM,
  input  logic [TNUM_2-1:0] tag_L2_MEM,
  input  logic [INUM_2-1:0] index_L2_MEM,
  input  logic [TNUM_2-1:0] write_tag_L2_MEM,
  input  logic [INUM_2-1:0] write_index_L2_MEM,
  input  line_t             write_data_L2_MEM,
  output logic              ready_MEM_L2,
  output line_t             read_data_MEM_L2,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);
  localparam int LA_W = TNUM_2 + INUM_2;
  localparam int RW = LA_W - COL_BITS;
  localparam int CW = $clog2(T_MISS);
  state_t state;
  logic is_wr, hit, row_valid;
  logic [LA_W-1:0] addr, req_addr;
  logic [RW-1:0] open_row;
  logic [CW-1:0] cnt;
  line_t wdata, rdata;
  logic req_hit;
  assign req_addr = write_L2_MEM ? {write_tag_L2_MEM, write_index_L2_MEM} : {tag_L2_MEM, index_L2_MEM};
  assign req_hit = row_valid && (req_addr[LA_W-1:COL_BITS] == open_row);
  mem_line_array #(.AW(AW), .INIT_FILE(INIT_FILE)) u_array (
    .clk(clk),
    .we(state == RESP && is_wr),
    .waddr(addr[AW-1:0]),
    .wdata(wdata),
    .raddr(addr[AW-1:0]),
    .rdata(rdata)
  );
  // BUSY holds L-1 cycles so ready is registered high for the cycle ending at edge k+L
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      ready_MEM_L2 <= 1'b0;
      read_data_MEM_L2 <= '0;
      hit_cnt <= '0;
      miss_cnt <= '0;
      row_valid <= 1'b0;
      open_row <= '0;
      cnt <= '0;
      is_wr <= 1'b0;
      hit <= 1'b0;
      addr <= '0;
      wdata <= '0;
    end else begin
      case (state)
        IDLE: if (read_L2_MEM || write_L2_MEM) begin
          state <= BUSY;
          is_wr <= write_L2_MEM;
          addr <= req_addr;
          wdata <= write_data_L2_MEM;
          hit <= req_hit;
          cnt <= req_hit ? CW'(T_HIT - 2) : CW'(T_MISS - 2);
        end
        BUSY: if (cnt == '0) begin
          state <= RESP;
          ready_MEM_L2 <= 1'b1;
          if (!is_wr) read_data_MEM_L2 <= rdata;
        end else cnt <= cnt - 1'b1;
        RESP: begin
          state <= GAP;
          ready_MEM_L2 <= 1'b0;
          open_row <= addr[LA_W-1:COL_BITS];
          row_valid <= 1'b1;
          if (hit) hit_cnt <= hit_cnt + 1'b1;
          else miss_cnt <= miss_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_ctrl_rowbuf.sv
// tb_mem_ctrl_rowbuf: directed scoreboard bench for latency, data and counters
module tb_mem_ctrl_rowbuf;
  import mem_pkg::*;
  logic clk = 1'b0, nrst = 1'b0;
  logic read_L2_MEM = 1'b0, write_L2_MEM = 1'b0;
  logic [17:0] tag_L2_MEM = '0, write_tag_L2_MEM = '0;
  logic [7:0] index_L2_MEM = '0, write_index_L2_MEM = '0;
  line_t write_data_L2_MEM = '0;
  logic ready_MEM_L2;
  line_t read_data_MEM_L2;
  logic [31:0] hit_cnt, miss_cnt;

  mem_ctrl_rowbuf dut (
    .clk(clk), .nrst(nrst),
    .read_L2_MEM(read_L2_MEM), .write_L2_MEM(write_L2_MEM),
    .tag_L2_MEM(tag_L2_MEM), .index_L2_MEM(index_L2_MEM),
    .write_tag_L2_MEM(write_tag_L2_MEM), .write_index_L2_MEM(write_index_L2_MEM),
    .write_data_L2_MEM(write_data_L2_MEM),
    .ready_MEM_L2(ready_MEM_L2), .read_data_MEM_L2(read_data_MEM_L2),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {int lat; bit rd; bit known; line_t data;} exp_t;
  exp_t q[$];
  line_t mem_m [int];
  bit rv_m = 0;
  logic [21:0] orow_m = '0;
  int hc = 0, mc = 0, total = 0, bad = 0;
  bit last_known = 0;
  line_t last_rd = '0;

  task automatic chk(input string tag, input line_t obs, input line_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_push(input bit wr, input logic [25:0] a, input line_t d);
    exp_t e;
    bit h;
    int ix;
    ix = int'(a[9:0]);
    h = rv_m && (a[25:4] == orow_m);
    e.lat = h ? 4 : 12;
    if (h) hc++; else mc++;
    rv_m = 1;
    orow_m = a[25:4];
    e.rd = !wr;
    e.known = mem_m.exists(ix);
    e.data = e.known ? mem_m[ix] : '0;
    if (wr) mem_m[ix] = d;
    q.push_back(e);
  endtask

  task automatic issue(input bit wr, input logic [25:0] a, input line_t d);
    model_push(wr, a, d);
    if (wr) begin
      write_L2_MEM = 1'b1; write_tag_L2_MEM = a[25:8]; write_index_L2_MEM = a[7:0]; write_data_L2_MEM = d;
    end else begin
      read_L2_MEM = 1'b1; tag_L2_MEM = a[25:8]; index_L2_MEM = a[7:0];
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!ready_MEM_L2 && n < 200);
  endtask

  task automatic pop_check(input int n, input int extra);
    exp_t e;
    chk("queue_nonempty", line_t'(q.size() > 0), line_t'(1));
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("latency", line_t'(n), line_t'(e.lat + extra));
      if (e.rd && e.known) chk("rdata", read_data_MEM_L2, e.data);
      if (!e.rd && last_known) chk("rdata_hold_on_write", read_data_MEM_L2, last_rd);
      if (e.rd) begin
        last_known = e.known;
        last_rd = e.data;
      end
    end
  endtask

  task automatic close_xact();
    read_L2_MEM = 1'b0;
    write_L2_MEM = 1'b0;
    @(posedge clk); #1;
    chk("ready_one_cycle", line_t'(ready_MEM_L2), line_t'(0));
    @(posedge clk); #1;
    chk("hit_cnt", line_t'(hit_cnt), line_t'(hc));
    chk("miss_cnt", line_t'(miss_cnt), line_t'(mc));
  endtask

  task automatic xact(input bit wr, input logic [25:0] a, input line_t d);
    int n;
    issue(wr, a, d);
    wait_ready(n);
    pop_check(n, 0);
    close_xact();
  endtask

  initial begin
    int n, pulses;
    line_t d_a5, d_3c, d_77;
    d_a5 = {64{8'hA5}};
    d_3c = {64{8'h3C}};
    d_77 = {64{8'h77}};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", line_t'(ready_MEM_L2), line_t'(0));
    chk("rst_rdata", read_data_MEM_L2, '0);
    chk("rst_hit_cnt", line_t'(hit_cnt), line_t'(0));
    chk("rst_miss_cnt", line_t'(miss_cnt), line_t'(0));
    nrst = 1'b1;
    xact(0, 26'h00105, '0);
    xact(1, 26'h00005, d_a5);
    xact(0, 26'h00006, '0);
    xact(0, 26'h00005, '0);
    xact(0, 26'h00005, '0);
    xact(0, 26'h00015, '0);
    xact(0, 26'h00005, '0);
    // write and read raised together: write first, read after the gap
    issue(1, 26'h00005, d_3c);
    issue(0, 26'h00005, '0);
    wait_ready(n);
    pop_check(n, 0);
    write_L2_MEM = 1'b0;
    wait_ready(n);
    pop_check(n, 2);
    close_xact();
    // reset in the middle of a busy access
    read_L2_MEM = 1'b1; tag_L2_MEM = '0; index_L2_MEM = 8'h15;
    repeat (3) @(posedge clk);
    #2;
    nrst = 1'b0;
    #1;
    chk("midrst_ready", line_t'(ready_MEM_L2), line_t'(0));
    chk("midrst_rdata", read_data_MEM_L2, '0);
    chk("midrst_hit_cnt", line_t'(hit_cnt), line_t'(0));
    chk("midrst_miss_cnt", line_t'(miss_cnt), line_t'(0));
    read_L2_MEM = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    rv_m = 0; hc = 0; mc = 0; last_known = 0;
    xact(0, 26'h00005, '0);
    // aliased line in a different row: storage shared, row switch costs a miss
    xact(1, 26'h00405, d_77);
    xact(0, 26'h00005, '0);
    // read held high across three back-to-back accesses
    issue(0, 26'h00105, '0);
    issue(0, 26'h00105, '0);
    issue(0, 26'h00105, '0);
    wait_ready(n);
    pop_check(n, 0);
    wait_ready(n);
    pop_check(n, 2);
    wait_ready(n);
    pop_check(n, 2);
    close_xact();
    pulses = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (ready_MEM_L2) pulses++;
    end
    chk("no_extra_pulse", line_t'(pulses), line_t'(0));
    chk("queue_drained", line_t'(q.size()), line_t'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
